led_flasher_multi: RTL and testbench

LED_FLASHER_MULTI -- requirements
Module: led_flasher_multi

---
 rtl/led_flasher_multi.sv | 120 ++++++++++++
 tb/tb_led_flasher_multi.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/led_flasher_multi.sv
// Multi-channel LED flasher: shared ms prescaler plus per-channel OFF/ON/BLINK/ONESHOT
// sequencers, each configured through a single write port.
module led_flasher_multi #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CNT_W-1:0]        cfg_on,
  output logic [N_CH-1:0]         led_out,
  output logic                    tick,
  output logic [N_CH-1:0]         busy
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned PRE_W = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    M_OFF     = 2'b00,
    M_ON      = 2'b01,
    M_BLINK   = 2'b10,
    M_ONESHOT = 2'b11
  } mode_t;

  logic [PRE_W-1:0]             pre_q, pre_d;
  logic                         tick_d;
  mode_t [N_CH-1:0]             mode_q, mode_d;
  logic  [N_CH-1:0][CNT_W-1:0]  period_q, period_d;
  logic  [N_CH-1:0][CNT_W-1:0]  on_q, on_d;
  logic  [N_CH-1:0][CNT_W-1:0]  phase_q, phase_d;
  logic  [N_CH-1:0]             led_d, busy_d;
  logic                         wr_ok;

  // Prescaler: tick is raised for the cycle following the terminal count.
  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    tick_d = 1'b0;
    if (pre_q == PRE_W'(PRESCALE - 1)) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Per-channel sequencers; a write to a channel wins over its tick advance.
  always_comb begin
    wr_ok    = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));
    mode_d   = mode_q;
    period_d = period_q;
    on_d     = on_q;
    phase_d  = phase_q;
    led_d    = '0;
    busy_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode_q[i])
        M_ON: led_d[i] = 1'b1;
        M_BLINK: begin
          led_d[i] = phase_q[i] < on_q[i];
          if (tick) begin
            // A zero period behaves as a period of one tick.
            if ((period_q[i] == '0) || (phase_q[i] >= period_q[i] - CNT_W'(1)))
              phase_d[i] = '0;
            else
              phase_d[i] = phase_q[i] + CNT_W'(1);
          end
        end
        M_ONESHOT: begin
          led_d[i]  = phase_q[i] < on_q[i];
          busy_d[i] = 1'b1;
          if (on_q[i] == '0) begin
            mode_d[i]  = M_OFF;
            phase_d[i] = '0;
          end else if (tick) begin
            if (phase_q[i] >= on_q[i] - CNT_W'(1)) begin
              mode_d[i]  = M_OFF;
              phase_d[i] = '0;
            end else begin
              phase_d[i] = phase_q[i] + CNT_W'(1);
            end
          end
        end
        default: led_d[i] = 1'b0;
      endcase
      if (wr_ok && (cfg_ch == CH_W'(i))) begin
        mode_d[i]   = mode_t'(cfg_mode);
        period_d[i] = cfg_period;
        on_d[i]     = cfg_on;
        phase_d[i]  = '0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q    <= '0;
      tick     <= 1'b0;
      mode_q   <= {N_CH{M_OFF}};
      period_q <= '0;
      on_q     <= '0;
      phase_q  <= '0;
      led_out  <= '0;
      busy     <= '0;
    end else begin
      pre_q    <= pre_d;
      tick     <= tick_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      on_q     <= on_d;
      phase_q  <= phase_d;
      led_out  <= led_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_led_flasher_multi.sv
// Directed bench for led_flasher_multi with PRESCALE=4, N_CH=3, CNT_W=8.
module tb_led_flasher_multi;

  localparam int unsigned N_CH     = 3;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned CNT_W    = 8;

  localparam logic [1:0] OFF     = 2'b00;
  localparam logic [1:0] ON      = 2'b01;
  localparam logic [1:0] BLINK   = 2'b10;
  localparam logic [1:0] ONESHOT = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_on;
  logic [N_CH-1:0]  led_out;
  logic             tick;
  logic [N_CH-1:0]  busy;

  int n_cmp = 0;
  int n_err = 0;

  led_flasher_multi #(.N_CH(N_CH), .PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_on     (cfg_on),
    .led_out    (led_out),
    .tick       (tick),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_cfg(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [7:0] per, input logic [7:0] on);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_on     = on;
  endtask

  // Called at a negedge; returns at the negedge right after the write edge.
  task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [7:0] per, input logic [7:0] on);
    drive_cfg(ch, mode, per, on);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Returns at a negedge where tick is high, so the next posedge advances channels.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (tick) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check_eq("wait_tick", 32'(tick), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    drive_cfg(2'd0, ON, 8'd5, 8'd5);
    repeat (5) @(negedge clk);
    check_eq("rst_led", 32'(led_out), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_tick", 32'(tick), 32'(0));

    // Ticks every 4 cycles, the first 4 edges after release.
    rst    = 1'b1;
    cfg_we = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check_eq($sformatf("rel_tick_%0d", e), 32'(tick), 32'(e % 4 == 0));
    end
    check_eq("rel_led", 32'(led_out), 32'(0));

    // ch0 BLINK 4/1 written on a tick edge; ch1 ON then OFF mid-window.
    wait_tick();
    write_cfg(2'd0, BLINK, 8'd4, 8'd1);
    for (int k = 0; k <= 32; k++) begin
      check_eq($sformatf("blk_led0_%0d", k), 32'(led_out[0]),
               32'((k >= 1) && (((k - 1) % 16) < 4)));
      check_eq($sformatf("blk_tick_%0d", k), 32'(tick), 32'(k % 4 == 3));
      check_eq($sformatf("blk_led1_%0d", k), 32'(led_out[1]), 32'((k >= 7) && (k <= 9)));
      check_eq($sformatf("blk_led2_%0d", k), 32'(led_out[2]), 32'(0));
      check_eq($sformatf("blk_busy_%0d", k), 32'(busy), 32'(0));
      if (k == 5)      drive_cfg(2'd1, ON, 8'd0, 8'd0);
      else if (k == 8) drive_cfg(2'd1, OFF, 8'd0, 8'd0);
      else             cfg_we = 1'b0;
      @(negedge clk);
    end
    cfg_we = 1'b0;

    // ch2 ONESHOT on=3 from a tick edge: busy/led for 12 cycles.
    wait_tick();
    write_cfg(2'd2, ONESHOT, 8'd0, 8'd3);
    for (int k = 0; k <= 16; k++) begin
      check_eq($sformatf("os_busy2_%0d", k), 32'(busy[2]), 32'((k >= 1) && (k <= 12)));
      check_eq($sformatf("os_led2_%0d", k), 32'(led_out[2]), 32'((k >= 1) && (k <= 12)));
      check_eq($sformatf("os_busy10_%0d", k), 32'(busy[1:0]), 32'(0));
      @(negedge clk);
    end

    // Rewrite mid-shot restarts from phase 0.
    wait_tick();
    write_cfg(2'd2, ONESHOT, 8'd0, 8'd3);
    for (int k = 0; k <= 20; k++) begin
      check_eq($sformatf("rs_busy2_%0d", k), 32'(busy[2]), 32'((k >= 1) && (k <= 16)));
      check_eq($sformatf("rs_led2_%0d", k), 32'(led_out[2]), 32'((k >= 1) && (k <= 16)));
      if (k == 5) drive_cfg(2'd2, ONESHOT, 8'd0, 8'd3);
      else        cfg_we = 1'b0;
      @(negedge clk);
    end
    cfg_we = 1'b0;

    // BLINK period=0, on=0 stays dark.
    write_cfg(2'd0, BLINK, 8'd0, 8'd0);
    for (int k = 0; k <= 10; k++) begin
      if (k >= 1) check_eq($sformatf("b00_led0_%0d", k), 32'(led_out[0]), 32'(0));
      @(negedge clk);
    end

    // BLINK on >= period stays lit.
    write_cfg(2'd0, BLINK, 8'd3, 8'd5);
    for (int k = 0; k <= 12; k++) begin
      if (k >= 1) check_eq($sformatf("b35_led0_%0d", k), 32'(led_out[0]), 32'(1));
      @(negedge clk);
    end

    // Out-of-range channel is ignored.
    write_cfg(2'd3, ONESHOT, 8'd0, 8'd5);
    for (int k = 0; k <= 4; k++) begin
      check_eq($sformatf("ch3_led_%0d", k), 32'(led_out), 32'(3'b001));
      check_eq($sformatf("ch3_busy_%0d", k), 32'(busy), 32'(0));
      @(negedge clk);
    end

    // ONESHOT on=0 reverts immediately without lighting.
    write_cfg(2'd2, ONESHOT, 8'd0, 8'd0);
    for (int k = 0; k <= 3; k++) begin
      check_eq($sformatf("os0_busy2_%0d", k), 32'(busy[2]), 32'(k == 1));
      check_eq($sformatf("os0_led2_%0d", k), 32'(led_out[2]), 32'(0));
      @(negedge clk);
    end

    // Reset mid-operation clears everything; channels stay off afterwards.
    write_cfg(2'd1, BLINK, 8'd4, 8'd2);
    write_cfg(2'd2, ONESHOT, 8'd0, 8'd200);
    repeat (3) @(negedge clk);
    check_eq("pre_rst_led0", 32'(led_out[0]), 32'(1));
    check_eq("pre_rst_busy", 32'(busy), 32'(3'b100));
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_led", 32'(led_out), 32'(0));
    check_eq("mid_rst_busy", 32'(busy), 32'(0));
    check_eq("mid_rst_tick", 32'(tick), 32'(0));
    rst = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      check_eq($sformatf("post_tick_%0d", e), 32'(tick), 32'(e % 4 == 0));
      check_eq($sformatf("post_led_%0d", e), 32'(led_out), 32'(0));
      check_eq($sformatf("post_busy_%0d", e), 32'(busy), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
